stage_sequencer: RTL and testbench
==================================

# stage_sequencer

Parametrised stage-enable sequencer for the pipelined Beta CPU; successor to the fixed five-stage clock controller. It generates one enable per pipeline stage, tracks in-flight destination registers in a shift-register scoreboard, stalls on RAW hazards, and inserts one bubble per JMP/BEQ/BNE. It drives the PC select with the resolved branch decision and halts fetch on EXIT. It sits between the instruction register of the read stage and the stage clock-enable fabric.

## Interface
- NSTAGES, 5, number of pipeline stages; legal range 4 to 8. Stage 0 is fetch, 1 is register read, 2 is ALU, NSTAGES-1 is register write.
- CNT_W, 32, width of the performance counters (used only with the macro).
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-high.
- alive  in  1  run enable; low has the same effect as reset, applied synchronously.
- instr_rd  in  32  instruction currently held at the register-read stage.
- branch_data  in  32  Ra value of the branch in the ALU stage.
- stage_en  out  NSTAGES  per-stage enable; bit k enables stage k.
- pcsel  out  2  PC mux select: 00 = PC+4, 10 = JMP, 01 = BEQ taken, 11 = BNE taken.
- halted  out  1  EXIT has drained and the pipeline is empty.
- stall_cycles, bubble_cycles  out  CNT_W  present only with STAGE_SEQ_PERF_EN.

## Operation
- State: occ[NSTAGES-1:0] marks which stages hold a valid instruction.
  - occ reset value is 1 (fetch only).
  - Next-state rules: occ'[k] = stage_en[k-1] for k ≥ 2, with the exceptions under "Stall" below. occ'[1] = stage_en[0]. occ'[0] = 1 unless the FSM is in HALT.
- Scoreboard: dst[k] (5 bits) and wr[k] for k = 2..NSTAGES-1.
  - When stage_en[1] is high, dst[2] <= instr_rd[25:21].
  - wr[2] <= (opcode != ST 6'h19) & (dst != 31).
  - Entries shift with occ. A bubble clears wr.
- Sources at the read stage:
  - Ra [20:16] always.
  - Rb [15:11] when [31:30] == 2'b10.
  - Rc [25:21] when the opcode is ST.
  - Register 31 never hazards.
- hazard = occ[1] & (any source equals dst[k] with wr[k] set, for any k in 2..NSTAGES-1).
- Decoded at the read stage (qualified by occ[1]):
  - ctrl: opcode 6'h1B, 6'h1D or 6'h1E.
  - exit: opcode 6'h3F. EXIT has no sources and never stalls.
- FSM states RUN, RESOLVE, HALT.
  - **RUN, hazard (stall):** stage_en = occ with bits [1:0] forced to 0. occ[1:0] and the read-stage instruction are held. A bubble enters stage 2; later stages advance.
  - **RUN, ctrl, no hazard:** stage_en[0] = 0 (no fetch). The branch advances to ALU. Go to RESOLVE.
  - **RUN, exit:** stage_en[0] = 0. EXIT advances as a NOP (wr = 0). Go to HALT.
  - **RUN, otherwise:** stage_en = occ.
  - **RESOLVE:** the branch is in stage 2 and occ[1] = 0.
    - taken = JMP | (BEQ & branch_data == 0) | (BNE & branch_data != 0).
    - pcsel = opcode encoding if taken, else 00.
    - stage_en[0] = 1, so the correct target is fetched.
    - Return to RUN.
  - **HALT:** occ'[0] = 0 and the pipeline drains. halted = (occ == 0). HALT is left only through rst or alive low.
- pcsel is 00 in every state except RESOLVE.
- Priority at the read stage: stall over ctrl; exit is exclusive with the other two by construction.

## Timing
- Reset and alive-low values: stage_en = 1 (occ = 1), pcsel = 00, halted = 0, FSM = RUN, all wr = 0, counters = 0.
- stage_en and pcsel are combinational from registered state plus instr_rd / branch_data. There are no combinational paths from stage_en back into the block.
- RAW stall length equals the number of scoreboard stages still ahead of the writer. With NSTAGES = 5 and the writer directly ahead, the stall is 3 cycles.
- Branch cost is exactly 1 bubble, whether or not the branch is taken. With the branch at read in cycle T, the correct fetch happens in cycle T+1.
- EXIT at read in cycle T gives halted = 1 from cycle T+NSTAGES-1.
- rst or alive dropping mid-stall or mid-RESOLVE returns to the reset values on the next edge (immediately for rst). No pcsel pulse leaks through.

## Configuration
- STAGE_SEQ_PERF_EN defined:
  - stall_cycles increments every cycle a hazard stall is applied.
  - bubble_cycles increments every cycle the FSM is in RESOLVE.
  - Both counters saturate at 2^CNT_W-1 and clear on rst or alive low.
- STAGE_SEQ_PERF_EN undefined: the counter ports and logic are absent; behaviour is otherwise identical.

## Test plan
- Reset: rst = 1 then released with alive = 1 -> stage_en = 00001, pcsel = 00, halted = 0. The next cycle with NOP (R31) traffic gives stage_en = 00011, reaching 11111 after 4 cycles.
- RAW: ADD R1,R2,R3 then ADD R4,R1,R5 back to back, NSTAGES = 5 -> 3 cycles with stage_en[1:0] = 00, then resume; stall_cycles = 3.
- R31: ADD R31 then an instruction reading R31 -> no stall.
- BEQ, branch_data = 0 -> one cycle with stage_en[0] = 0, then pcsel = 01 with stage_en[0] = 1. Repeat with branch_data = 5 -> pcsel = 00; bubble_cycles = 1 each time.
- JMP followed by a stalled dependent -> pcsel = 10 in RESOLVE. The stall is evaluated only once the post-branch instruction reaches read.
- EXIT with NSTAGES = 6 -> stage_en[0] = 0 from cycle T, halted = 1 at T+5. Dropping alive mid-drain -> stage_en = 000001 and halted = 0 on the next edge.

Source files
------------

// File: rtl/stage_sequencer_if.sv
// Control bundle between the read-stage instruction register and the stage clock-enable fabric.
interface stage_sequencer_if #(
  parameter int NSTAGES = 5
);
  logic               alive;
  logic [31:0]        instr_rd;
  logic [31:0]        branch_data;
  logic [NSTAGES-1:0] stage_en;
  logic [1:0]         pcsel;
  logic               halted;

  modport master (output alive, instr_rd, branch_data, input stage_en, pcsel, halted);
  modport slave  (input alive, instr_rd, branch_data, output stage_en, pcsel, halted);
endinterface

// File: rtl/stage_sequencer.sv
// Stage-enable sequencer for the pipelined Beta: RAW scoreboard stalls, one-bubble branch resolve, EXIT drain.
// Defining STAGE_SEQ_PERF_EN adds saturating stall_cycles / bubble_cycles counter ports.
//
// state   | meaning
// RUN     | normal issue; read stage stalls on RAW hazards
// RESOLVE | branch sits in ALU; drive pcsel and refetch
// HALT    | EXIT issued; fetch stopped, pipeline draining
module stage_sequencer #(
  parameter int NSTAGES = 5,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  stage_sequencer_if.slave seq
`ifdef STAGE_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_cycles
`endif
);

  localparam logic [5:0] OP_ST   = 6'h19;
  localparam logic [5:0] OP_JMP  = 6'h1B;
  localparam logic [5:0] OP_BEQ  = 6'h1D;
  localparam logic [5:0] OP_BNE  = 6'h1E;
  localparam logic [5:0] OP_EXIT = 6'h3F;
  localparam logic [NSTAGES-1:0] OCC_RST = {{(NSTAGES-1){1'b0}}, 1'b1};

  if (NSTAGES < 4 || NSTAGES > 8 || CNT_W < 1) begin : g_bad_param
    $error("stage_sequencer: NSTAGES must be 4..8 and CNT_W positive");
  end

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RESOLVE = 2'd1,
    HALT    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [NSTAGES-1:0]      occ_q, occ_d, stage_en;
  logic [NSTAGES-1:2]      wr_q;
  logic [NSTAGES-1:2][4:0] dst_q;
  logic [1:0]              br_q, br_code, pcsel;
  logic [5:0]              opcode;
  logic [4:0]              rc, ra, rb;
  logic                    is_st, is_exit, is_ctrl, use_rb;
  logic                    raw, hazard, ctrl, exit_rd, stall, taken, wr_new;
  logic                    unused_lsbs;

  assign opcode  = seq.instr_rd[31:26];
  assign rc      = seq.instr_rd[25:21];
  assign ra      = seq.instr_rd[20:16];
  assign rb      = seq.instr_rd[15:11];
  assign is_st   = (opcode == OP_ST);
  assign is_exit = (opcode == OP_EXIT);
  assign is_ctrl = (opcode == OP_JMP) || (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign use_rb  = (seq.instr_rd[31:30] == 2'b10);
  assign unused_lsbs = ^seq.instr_rd[10:0];

  // A store's Rc is a data source, not a destination.
  always_comb begin
    raw = 1'b0;
    for (int k = 2; k < NSTAGES; k++) begin
      if (wr_q[k] && ((ra != 5'd31 && ra == dst_q[k]) ||
                      (use_rb && rb != 5'd31 && rb == dst_q[k]) ||
                      (is_st && rc != 5'd31 && rc == dst_q[k])))
        raw = 1'b1;
    end
  end

  assign hazard  = occ_q[1] & ~is_exit & raw;
  assign ctrl    = occ_q[1] & is_ctrl;
  assign exit_rd = occ_q[1] & is_exit;
  assign wr_new  = ~is_st & ~is_exit & (rc != 5'd31);

  always_comb begin
    case (opcode)
      OP_JMP:  br_code = 2'b10;
      OP_BEQ:  br_code = 2'b01;
      OP_BNE:  br_code = 2'b11;
      default: br_code = 2'b00;
    endcase
  end

  assign taken = (br_q == 2'b10) ||
                 (br_q == 2'b01 && seq.branch_data == '0) ||
                 (br_q == 2'b11 && seq.branch_data != '0);

  always_comb begin
    state_d  = state_q;
    stage_en = occ_q;
    pcsel    = 2'b00;
    stall    = 1'b0;
    case (state_q)
      RUN: begin
        if (hazard) begin
          stage_en[1:0] = 2'b00;
          stall         = 1'b1;
        end else if (ctrl) begin
          stage_en[0] = 1'b0;
          state_d     = RESOLVE;
        end else if (exit_rd) begin
          stage_en[0] = 1'b0;
          state_d     = HALT;
        end
      end
      RESOLVE: begin
        stage_en[0] = 1'b1;
        if (taken) pcsel = br_q;
        state_d = RUN;
      end
      HALT: stage_en[0] = 1'b0;
      default: state_d = RUN;
    endcase
  end

  // A stall holds fetch/read in place and lets a bubble into stage 2.
  always_comb begin
    occ_d    = {stage_en[NSTAGES-2:0], 1'b0};
    occ_d[0] = (state_q != HALT);
    if (stall) occ_d[1] = occ_q[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      occ_q   <= OCC_RST;
    end else if (!seq.alive) begin
      state_q <= RUN;
      occ_q   <= OCC_RST;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      dst_q <= '0;
      br_q  <= 2'b00;
    end else if (!seq.alive) begin
      wr_q  <= '0;
      dst_q <= '0;
      br_q  <= 2'b00;
    end else begin
      wr_q[2] <= stage_en[1] & wr_new;
      if (stage_en[1]) dst_q[2] <= rc;
      for (int k = 3; k < NSTAGES; k++) begin
        wr_q[k] <= stage_en[k-1] & wr_q[k-1];
        if (stage_en[k-1]) dst_q[k] <= dst_q[k-1];
      end
      if (state_q == RUN && state_d == RESOLVE) br_q <= br_code;
    end
  end

`ifdef STAGE_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
    end else if (!seq.alive) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
    end else begin
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
      if (state_q == RESOLVE && bubble_cycles != '1) bubble_cycles <= bubble_cycles + CNT_W'(1);
    end
  end
`endif

  assign seq.stage_en = stage_en;
  assign seq.pcsel    = pcsel;
  assign seq.halted   = (state_q == HALT) && (occ_q == '0);

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: a 5-stage and a 6-stage instance share clock and stimulus.
module tb_stage_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP  = {6'h20, 5'd31, 5'd31, 5'd31, 11'd0};
  localparam logic [31:0] EXIT = {6'h3F, 26'd0};

  stage_sequencer_if #(.NSTAGES(5)) if5 ();
  stage_sequencer_if #(.NSTAGES(6)) if6 ();

`ifdef STAGE_SEQ_PERF_EN
  logic [31:0] stall5, bubble5, stall6, bubble6;
`endif

  stage_sequencer #(.NSTAGES(5), .CNT_W(32)) dut5 (
    .clk(clk), .rst(rst), .seq(if5)
`ifdef STAGE_SEQ_PERF_EN
    , .stall_cycles(stall5), .bubble_cycles(bubble5)
`endif
  );

  stage_sequencer #(.NSTAGES(6), .CNT_W(32)) dut6 (
    .clk(clk), .rst(rst), .seq(if6)
`ifdef STAGE_SEQ_PERF_EN
    , .stall_cycles(stall6), .bubble_cycles(bubble6)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] op(input logic [5:0] opc, input logic [4:0] rc,
                                     input logic [4:0] ra, input logic [4:0] rb);
    return {opc, rc, ra, rb, 11'd0};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [31:0] bd);
    if5.instr_rd = instr;
    if6.instr_rd = instr;
    if5.branch_data = bd;
    if6.branch_data = bd;
  endtask

  task automatic set_alive(input logic a);
    if5.alive = a;
    if6.alive = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_full();
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_alive(1'b1);
    drive(NOP, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    logic [4:0] want [4];
    want = '{5'b00011, 5'b00111, 5'b01111, 5'b11111};
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_alive(1'b1);
    drive(NOP, 32'd0);
    #1;
    checks++;
    if (if5.stage_en !== 5'b00001) begin errors++; $display("FAIL reset stage_en: got %b expected 00001", if5.stage_en); end
    checks++;
    if (if5.pcsel !== 2'b00) begin errors++; $display("FAIL reset pcsel: got %b expected 00", if5.pcsel); end
    checks++;
    if (if5.halted !== 1'b0) begin errors++; $display("FAIL reset halted: got %b expected 0", if5.halted); end
    checks++;
    if (if6.stage_en !== 6'b000001) begin errors++; $display("FAIL reset stage_en6: got %b expected 000001", if6.stage_en); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (if5.stage_en !== 5'b00001) begin errors++; $display("FAIL release stage_en: got %b expected 00001", if5.stage_en); end
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      checks++;
      if (if5.stage_en !== want[i]) begin errors++; $display("FAIL fill c%0d stage_en: got %b expected %b", i, if5.stage_en, want[i]); end
    end
  endtask

  task automatic test_raw();
    logic [31:0] ins [6];
    logic [4:0] want [6];
    ins  = '{op(6'h20, 5'd1, 5'd2, 5'd3), op(6'h20, 5'd4, 5'd1, 5'd5), op(6'h20, 5'd4, 5'd1, 5'd5),
             op(6'h20, 5'd4, 5'd1, 5'd5), op(6'h20, 5'd4, 5'd1, 5'd5), NOP};
    want = '{5'b11111, 5'b11100, 5'b11000, 5'b10000, 5'b00011, 5'b00111};
    init_full();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      drive(ins[i], 32'd0);
      #1;
      checks++;
      if (if5.stage_en !== want[i]) begin errors++; $display("FAIL raw c%0d stage_en: got %b expected %b", i, if5.stage_en, want[i]); end
      checks++;
      if (if5.pcsel !== 2'b00) begin errors++; $display("FAIL raw c%0d pcsel: got %b expected 00", i, if5.pcsel); end
    end
`ifdef STAGE_SEQ_PERF_EN
    checks++;
    if (stall5 !== 32'd3) begin errors++; $display("FAIL raw stall_cycles: got %0d expected 3", stall5); end
`endif
  endtask

  task automatic test_r31();
    logic [31:0] ins [4];
    logic [4:0] want [4];
    ins  = '{op(6'h20, 5'd31, 5'd2, 5'd3), op(6'h20, 5'd4, 5'd31, 5'd5),
             op(6'h30, 5'd8, 5'd31, 5'd4), op(6'h20, 5'd9, 5'd31, 5'd8)};
    want = '{5'b11111, 5'b11111, 5'b11111, 5'b11100};
    init_full();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      drive(ins[i], 32'd0);
      #1;
      checks++;
      if (if5.stage_en !== want[i]) begin errors++; $display("FAIL r31/rb c%0d stage_en: got %b expected %b", i, if5.stage_en, want[i]); end
    end
  endtask

  task automatic test_store();
    logic [31:0] ins [4];
    logic [4:0] want [4];
    ins  = '{op(6'h19, 5'd7, 5'd31, 5'd0), op(6'h20, 5'd4, 5'd5, 5'd7),
             op(6'h20, 5'd1, 5'd2, 5'd3), op(6'h19, 5'd1, 5'd31, 5'd0)};
    want = '{5'b11111, 5'b11111, 5'b11111, 5'b11100};
    init_full();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      drive(ins[i], 32'd0);
      #1;
      checks++;
      if (if5.stage_en !== want[i]) begin errors++; $display("FAIL store c%0d stage_en: got %b expected %b", i, if5.stage_en, want[i]); end
    end
  endtask

  task automatic test_branch(input logic [5:0] opc, input logic [31:0] bd, input logic [1:0] want_pc);
    init_full();
    drive(op(opc, 5'd31, 5'd2, 5'd31), 32'd0);
    #1;
    checks++;
    if (if5.stage_en !== 5'b11110 || if5.pcsel !== 2'b00) begin
      errors++; $display("FAIL branch %h read: got en=%b pc=%b expected en=11110 pc=00", opc, if5.stage_en, if5.pcsel);
    end
    tick();
    drive(NOP, bd);
    #1;
    checks++;
    if (if5.stage_en !== 5'b11101 || if5.pcsel !== want_pc) begin
      errors++; $display("FAIL branch %h resolve bd=%0d: got en=%b pc=%b expected en=11101 pc=%b", opc, bd, if5.stage_en, if5.pcsel, want_pc);
    end
    tick();
    drive(NOP, 32'd0);
    #1;
    checks++;
    if (if5.stage_en !== 5'b11011 || if5.pcsel !== 2'b00) begin
      errors++; $display("FAIL branch %h after: got en=%b pc=%b expected en=11011 pc=00", opc, if5.stage_en, if5.pcsel);
    end
`ifdef STAGE_SEQ_PERF_EN
    checks++;
    if (bubble5 !== 32'd1) begin errors++; $display("FAIL branch bubble_cycles: got %0d expected 1", bubble5); end
`endif
  endtask

  task automatic test_jmp();
    logic [31:0] ins [5];
    logic [4:0] want_en [5];
    logic [1:0] want_pc [5];
    ins     = '{op(6'h1B, 5'd3, 5'd2, 5'd31), op(6'h20, 5'd4, 5'd3, 5'd5), op(6'h20, 5'd4, 5'd3, 5'd5),
                op(6'h20, 5'd4, 5'd3, 5'd5), op(6'h20, 5'd4, 5'd3, 5'd5)};
    want_en = '{5'b11110, 5'b11101, 5'b11000, 5'b10000, 5'b00011};
    want_pc = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    init_full();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      drive(ins[i], 32'd0);
      #1;
      checks++;
      if (if5.stage_en !== want_en[i] || if5.pcsel !== want_pc[i]) begin
        errors++; $display("FAIL jmp c%0d: got en=%b pc=%b expected en=%b pc=%b", i, if5.stage_en, if5.pcsel, want_en[i], want_pc[i]);
      end
    end
  endtask

  task automatic test_exit();
    logic [5:0] want_en [7];
    logic want_h [7];
    want_en = '{6'b111110, 6'b111100, 6'b111000, 6'b110000, 6'b100000, 6'b000000, 6'b000000};
    want_h  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    init_full();
`ifdef STAGE_SEQ_PERF_EN
    checks++;
    if (stall6 !== 32'd0 || bubble6 !== 32'd0) begin errors++; $display("FAIL exit counters: got %0d/%0d expected 0/0", stall6, bubble6); end
`endif
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      drive((i == 0) ? EXIT : NOP, 32'd0);
      #1;
      checks++;
      if (if6.stage_en !== want_en[i] || if6.halted !== want_h[i]) begin
        errors++; $display("FAIL exit T+%0d: got en=%b halted=%b expected en=%b halted=%b", i, if6.stage_en, if6.halted, want_en[i], want_h[i]);
      end
    end
    set_alive(1'b0);
    tick();
    #1;
    checks++;
    if (if6.stage_en !== 6'b000001 || if6.halted !== 1'b0) begin
      errors++; $display("FAIL exit alive-low: got en=%b halted=%b expected en=000001 halted=0", if6.stage_en, if6.halted);
    end
    init_full();
    drive(EXIT, 32'd0);
    tick();
    drive(NOP, 32'd0);
    tick();
    set_alive(1'b0);
    tick();
    #1;
    checks++;
    if (if6.stage_en !== 6'b000001 || if6.halted !== 1'b0) begin
      errors++; $display("FAIL exit mid-drain alive-low: got en=%b halted=%b expected en=000001 halted=0", if6.stage_en, if6.halted);
    end
    set_alive(1'b1);
    tick();
    #1;
    checks++;
    if (if6.stage_en !== 6'b000011) begin errors++; $display("FAIL exit restart: got en=%b expected 000011", if6.stage_en); end
  endtask

  task automatic test_abort();
    init_full();
    drive(op(6'h1D, 5'd31, 5'd2, 5'd31), 32'd0);
    tick();
    drive(NOP, 32'd0);
    #1;
    checks++;
    if (if5.pcsel !== 2'b01) begin errors++; $display("FAIL abort resolve pcsel: got %b expected 01", if5.pcsel); end
    rst = 1'b1;
    #1;
    checks++;
    if (if5.pcsel !== 2'b00 || if5.stage_en !== 5'b00001) begin
      errors++; $display("FAIL abort rst: got en=%b pc=%b expected en=00001 pc=00", if5.stage_en, if5.pcsel);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    init_full();
    drive(op(6'h20, 5'd1, 5'd2, 5'd3), 32'd0);
    tick();
    drive(op(6'h20, 5'd4, 5'd1, 5'd5), 32'd0);
    #1;
    checks++;
    if (if5.stage_en !== 5'b11100) begin errors++; $display("FAIL abort stall: got en=%b expected 11100", if5.stage_en); end
    tick();
    set_alive(1'b0);
    tick();
    #1;
    checks++;
    if (if5.stage_en !== 5'b00001 || if5.pcsel !== 2'b00) begin
      errors++; $display("FAIL abort alive-low: got en=%b pc=%b expected en=00001 pc=00", if5.stage_en, if5.pcsel);
    end
`ifdef STAGE_SEQ_PERF_EN
    checks++;
    if (stall5 !== 32'd0) begin errors++; $display("FAIL abort stall_cycles: got %0d expected 0", stall5); end
`endif
    set_alive(1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_alive(1'b1);
    drive(NOP, 32'd0);
    test_reset();
    test_raw();
    test_r31();
    test_store();
    test_branch(6'h1D, 32'd0, 2'b01);
    test_branch(6'h1D, 32'd5, 2'b00);
    test_branch(6'h1E, 32'd5, 2'b11);
    test_branch(6'h1E, 32'd0, 2'b00);
    test_jmp();
    test_exit();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
